fetch_stage: RTL and testbench

// - Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RISC-V core.
// - Holds the PC, addresses instruction memory and latches {pc, instr, valid} into IF/ID.
// - Takes PC_Write / If_id_write from the hazard detection unit for load-use stalls.
// - Takes branch_taken / branch_target from EX for redirect and flush.
// - Presents if_id_rs1 / if_id_rs2 back to the hazard unit.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/pc_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants for the 5-stage RISC-V pipeline: widths, bubble encoding
// and register-field positions within an instruction word.
package pipeline_pkg;

    localparam int XLEN      = 64;
    localparam int INSTR_W   = 32;
    localparam int REG_IDX_W = 5;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int PERF_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [REG_IDX_W-1:0] rs1_of(input logic [INSTR_W-1:0] instr);
        return instr[RS1_LSB +: REG_IDX_W];
    endfunction

    function automatic logic [REG_IDX_W-1:0] rs2_of(input logic [INSTR_W-1:0] instr);
        return instr[RS2_LSB +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: sequential +4 advance, EX-stage redirect and stall hold.
module pc_reg #(
    parameter int               XLEN     = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc
);
    import pipeline_pkg::*;

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // Instructions are word aligned, so the low target bits are dropped.
    logic [1:0] unused_target_lsbs;
    assign unused_target_lsbs = branch_target[1:0];

    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = {branch_target[XLEN-1:2], 2'b00};
        end else if (pc_write) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with the IF/ID pipeline register.
// Define FETCH_PERF_EN to build the stall/flush performance counters.
module fetch_stage #(
    parameter int                               XLEN      = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0]                  RESET_PC  = '0,
    parameter logic [pipeline_pkg::INSTR_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 PC_Write,
    input  logic                                 If_id_write,
    input  logic                                 branch_taken,
    input  logic [XLEN-1:0]                      branch_target,
    output logic [XLEN-1:0]                      imem_addr,
    input  logic [pipeline_pkg::INSTR_W-1:0]     imem_rdata,
    output logic [XLEN-1:0]                      if_id_pc,
    output logic [pipeline_pkg::INSTR_W-1:0]     if_id_instr,
    output logic                                 if_id_valid,
    output logic [pipeline_pkg::REG_IDX_W-1:0]   if_id_rs1,
    output logic [pipeline_pkg::REG_IDX_W-1:0]   if_id_rs2,
    output logic [pipeline_pkg::PERF_W-1:0]      stall_cycles,
    output logic [pipeline_pkg::PERF_W-1:0]      flush_count
);
    import pipeline_pkg::*;

    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    if_id_pc_d,    if_id_pc_q;
    logic [INSTR_W-1:0] if_id_instr_d, if_id_instr_q;
    logic               if_id_valid_d, if_id_valid_q;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (PC_Write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc)
    );

    assign imem_addr = pc;

    // A redirect squashes the wrong-path word even while the hazard unit stalls.
    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (branch_taken) begin
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (If_id_write) begin
            if_id_pc_d    = pc;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_rs1   = rs1_of(if_id_instr_q);
    assign if_id_rs2   = rs2_of(if_id_instr_q);

`ifdef FETCH_PERF_EN
    logic [PERF_W-1:0] stall_cycles_d, stall_cycles_q;
    logic [PERF_W-1:0] flush_count_d,  flush_count_q;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (branch_taken) begin
            if (flush_count_q != '1) flush_count_d = flush_count_q + PERF_W'(1);
        end else if (!PC_Write) begin
            if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem returns 32'hA0 + address.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        PC_Write;
    logic        If_id_write;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int tests_run;
    int tests_failed;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .PC_Write      (PC_Write),
        .If_id_write   (If_id_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .if_id_rs1     (if_id_rs1),
        .if_id_rs2     (if_id_rs2),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = 32'hA0 + imem_addr[31:0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic iw, input logic bt, input logic [63:0] tgt);
        PC_Write      = pw;
        If_id_write   = iw;
        branch_taken  = bt;
        branch_target = tgt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        step();
        reset = 1'b0;
    endtask

    task automatic check_state(input string name, input logic [63:0] exp_pc,
                               input logic [63:0] exp_if_pc, input logic [31:0] exp_instr,
                               input logic exp_valid);
        tests_run++;
        if (imem_addr !== exp_pc || if_id_pc !== exp_if_pc ||
            if_id_instr !== exp_instr || if_id_valid !== exp_valid) begin
            tests_failed++;
            $display("[TB] FAIL %s: got pc=%h if_pc=%h instr=%h valid=%b, expected pc=%h if_pc=%h instr=%h valid=%b",
                     name, imem_addr, if_id_pc, if_id_instr, if_id_valid,
                     exp_pc, exp_if_pc, exp_instr, exp_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_state("reset", 64'h0, 64'h0, 32'h13, 1'b0);
        tests_run++;
        if (if_id_rs1 !== 5'd0 || if_id_rs2 !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rs: got rs1=%0d rs2=%0d, expected 0 0", if_id_rs1, if_id_rs2);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        step();
        check_state("seq_edge1", 64'd4, 64'd0, 32'hA0, 1'b1);
        step();
        check_state("seq_edge2", 64'd8, 64'd4, 32'hA4, 1'b1);
        step();
        check_state("seq_edge3", 64'd12, 64'd8, 32'hA8, 1'b1);
    endtask

    task automatic test_load_use_stall();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        step();
        step();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        step();
        check_state("stall_hold", 64'd8, 64'd4, 32'hA4, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        step();
        check_state("stall_resume", 64'd12, 64'd8, 32'hA8, 1'b1);
    endtask

    task automatic test_flush_during_stall();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        step();
        step();
        drive(1'b0, 1'b0, 1'b1, 64'h103);
        step();
        check_state("flush_in_stall", 64'h100, 64'h0, 32'h13, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        step();
        check_state("flush_target_fetch", 64'h104, 64'h100, 32'h1A0, 1'b1);
    endtask

    task automatic test_drop_and_duplicate();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++) step();
        check_state("pre_drop", 64'd16, 64'd12, 32'hAC, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        step();
        check_state("drop_fetch", 64'd20, 64'd12, 32'hAC, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 64'h0);
        step();
        check_state("duplicate_1", 64'd20, 64'd20, 32'hB4, 1'b1);
        step();
        check_state("duplicate_2", 64'd20, 64'd20, 32'hB4, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check_state("wrap_redirect", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h13, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        step();
        check_state("wrap_advance", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h9C, 1'b1);
    endtask

    task automatic test_rs_decode();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 64'h0128_8000);
        step();
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        step();
        check_state("rs_word", 64'h0128_8004, 64'h0128_8000, 32'h0128_80A0, 1'b1);
        tests_run++;
        if (if_id_rs1 !== 5'd17 || if_id_rs2 !== 5'd18) begin
            tests_failed++;
            $display("[TB] FAIL rs_decode: got rs1=%0d rs2=%0d, expected 17 18", if_id_rs1, if_id_rs2);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        step();
        step();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 64'h400);
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        check_state("reset_mid_run", 64'h0, 64'h0, 32'h13, 1'b0);
    endtask

    task automatic test_perf_counters();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 5; i++) step();
        drive(1'b0, 1'b0, 1'b1, 64'h200);
        step();
        drive(1'b1, 1'b1, 1'b1, 64'h300);
        step();
        drive(1'b1, 1'b1, 1'b0, 64'h0);
        step();
`ifdef FETCH_PERF_EN
        tests_run++;
        if (stall_cycles !== 32'd5 || flush_count !== 32'd2) begin
            tests_failed++;
            $display("[TB] FAIL perf_counts: got stall=%0d flush=%0d, expected 5 2", stall_cycles, flush_count);
        end
`else
        tests_run++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL perf_tied: got stall=%0d flush=%0d, expected 0 0", stall_cycles, flush_count);
        end
`endif
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 64'h0);
        step();
        reset = 1'b0;
        tests_run++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL perf_reset: got stall=%0d flush=%0d, expected 0 0", stall_cycles, flush_count);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        test_reset();
        test_sequential();
        test_load_use_stall();
        test_flush_during_stall();
        test_drop_and_duplicate();
        test_wrap();
        test_rs_decode();
        test_reset_mid_run();
        test_perf_counters();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
